// File: rtl/systolic_seq_ctrl.sv
// Job sequencer for an N x N weight-stationary systolic array.
// It runs weight preload, then activation streaming, then pipeline drain, with skewed column valids.
module systolic_seq_ctrl #(
  parameter int unsigned N         = 4,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       start_i,
  input  logic [CNT_WIDTH-1:0]       num_vec_i,
  input  logic                       stall_i,
  output logic                       busy_o,
  output logic                       done_o,
  output logic                       wt_load_en_o,
  output logic [$clog2(N)-1:0]       wt_row_o,
  output logic                       act_rd_en_o,
  output logic [CNT_WIDTH-1:0]       act_rd_addr_o,
  output logic                       acc_en_o,
  output logic [N-1:0]               col_valid_o,
  output logic                       res_valid_o,
  output logic [CNT_WIDTH-1:0]       res_idx_o
);

  localparam int unsigned ROW_WIDTH = $clog2(N);
  localparam int unsigned DL        = 2 * N;
  // Phase counter must hold both M-1 and 2N-1.
  localparam int unsigned PW = (CNT_WIDTH > $clog2(DL)) ? CNT_WIDTH : $clog2(DL);

  typedef enum logic [2:0] {StIdle, StLoadW, StStream, StDrain, StDone} state_e;

  state_e               state_q, state_d;
  logic [PW-1:0]        cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] m_q, m_d;
  logic [CNT_WIDTH-1:0] res_cnt_q, res_cnt_d;
  logic [DL-1:0]        dly_q, dly_d;
  logic                 active, act_rd, res_fire;

  assign active   = (state_q inside {StLoadW, StStream, StDrain}) && !stall_i;
  assign act_rd   = (state_q == StStream) && !stall_i;
  assign res_fire = active && dly_q[DL-1];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    m_d           = m_q;
    res_cnt_d     = res_cnt_q;
    dly_d         = dly_q;
    busy_o        = (state_q != StIdle);
    done_o        = 1'b0;
    wt_load_en_o  = 1'b0;
    wt_row_o      = '0;
    act_rd_en_o   = act_rd;
    act_rd_addr_o = '0;
    acc_en_o      = 1'b0;
    col_valid_o   = active ? dly_q[N-1:0] : '0;
    res_valid_o   = res_fire;
    res_idx_o     = res_fire ? res_cnt_q : '0;

    unique case (state_q)
      StIdle: begin
        if (start_i && (num_vec_i != '0)) begin
          m_d       = num_vec_i;
          cnt_d     = '0;
          res_cnt_d = '0;
          dly_d     = '0;
          state_d   = StLoadW;
        end
      end
      StLoadW: begin
        wt_row_o     = cnt_q[ROW_WIDTH-1:0];
        wt_load_en_o = active;
        if (active) begin
          if (cnt_q == PW'(N - 1)) begin
            cnt_d   = '0;
            state_d = StStream;
          end else begin
            cnt_d = cnt_q + PW'(1);
          end
        end
      end
      StStream: begin
        act_rd_addr_o = cnt_q[CNT_WIDTH-1:0];
        acc_en_o      = active;
        if (active) begin
          if (cnt_q == PW'(m_q) - PW'(1)) begin
            cnt_d   = '0;
            state_d = StDrain;
          end else begin
            cnt_d = cnt_q + PW'(1);
          end
        end
      end
      StDrain: begin
        acc_en_o = active;
        if (active) begin
          if (cnt_q == PW'(DL - 1)) begin
            cnt_d   = '0;
            state_d = StDone;
          end else begin
            cnt_d = cnt_q + PW'(1);
          end
        end
      end
      StDone: begin
        done_o  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Delay line advances only on active cycles; tap k is act_rd delayed k+1 active cycles.
    if (active) begin
      dly_d = {dly_q[DL-2:0], act_rd};
    end
    if (res_fire) begin
      res_cnt_d = res_cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      m_q       <= '0;
      res_cnt_q <= '0;
      dly_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      m_q       <= m_d;
      res_cnt_q <= res_cnt_d;
      dly_q     <= dly_d;
    end
  end

endmodule

// File: tb/tb_systolic_seq_ctrl.sv
// Directed bench for systolic_seq_ctrl (N=4, CNT_WIDTH=8); cycle c starts at the c-th posedge of a test.
module tb_systolic_seq_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       start_i;
  logic [7:0] num_vec_i;
  logic       stall_i;
  logic       busy_o, done_o, wt_load_en_o, act_rd_en_o, acc_en_o, res_valid_o;
  logic [1:0] wt_row_o;
  logic [7:0] act_rd_addr_o, res_idx_o;
  logic [3:0] col_valid_o;

  int checks   = 0;
  int failures = 0;

  systolic_seq_ctrl #(.N(4), .CNT_WIDTH(8)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .start_i      (start_i),
    .num_vec_i    (num_vec_i),
    .stall_i      (stall_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .wt_load_en_o (wt_load_en_o),
    .wt_row_o     (wt_row_o),
    .act_rd_en_o  (act_rd_en_o),
    .act_rd_addr_o(act_rd_addr_o),
    .acc_en_o     (acc_en_o),
    .col_valid_o  (col_valid_o),
    .res_valid_o  (res_valid_o),
    .res_idx_o    (res_idx_o)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  // Index buses are only meaningful alongside their strobe, so they are masked otherwise.
  function automatic logic [27:0] obs();
    return {busy_o, done_o, wt_load_en_o, (wt_load_en_o ? wt_row_o : 2'd0), act_rd_en_o,
            (act_rd_en_o ? act_rd_addr_o : 8'd0), acc_en_o, col_valid_o, res_valid_o,
            (res_valid_o ? res_idx_o : 8'd0)};
  endfunction

  function automatic logic [27:0] raw_obs();
    return {busy_o, done_o, wt_load_en_o, wt_row_o, act_rd_en_o, act_rd_addr_o, acc_en_o,
            col_valid_o, res_valid_o, res_idx_o};
  endfunction

  function automatic logic [27:0] expv(input logic busy, input logic done, input logic wt,
                                       input logic [1:0] row, input logic act,
                                       input logic [7:0] addr, input logic acc,
                                       input logic [3:0] cv, input logic rv,
                                       input logic [7:0] idx);
    return {busy, done, wt, row, act, addr, acc, cv, rv, idx};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0; start_i = 1'b0; stall_i = 1'b0; num_vec_i = 8'd0;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (raw_obs() !== 28'd0) begin
      failures++;
      $display("FAIL reset_held: got %h required %h", raw_obs(), 28'd0);
    end
    tick();
    rstn = 1'b1;
    @(negedge clk);
    checks++;
    if (raw_obs() !== 28'd0) begin
      failures++;
      $display("FAIL reset_release: got %h required %h", raw_obs(), 28'd0);
    end
  endtask

  // Unstalled job of m vectors started at c0; timeline from the nominal schedule.
  task automatic test_job(input int m, input string name);
    logic [27:0] e;
    logic [3:0]  cv;
    logic        wt, act, rv;
    for (int c = 0; c <= 14 + m; c++) begin
      tick();
      start_i   = (c == 0);
      num_vec_i = (c == 0) ? 8'(m) : 8'd7;
      @(negedge clk);
      for (int j = 0; j < 4; j++) cv[j] = (c >= 6 + j) && (c <= 5 + m + j);
      wt  = (c >= 1) && (c <= 4);
      act = (c >= 5) && (c <= 4 + m);
      rv  = (c >= 13) && (c <= 12 + m);
      e = expv((c >= 1) && (c <= 13 + m), c == 13 + m, wt, wt ? 2'(c - 1) : 2'd0,
               act, act ? 8'(c - 5) : 8'd0, (c >= 5) && (c <= 12 + m), cv,
               rv, rv ? 8'(c - 13) : 8'd0);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL %s c%0d: got %h required %h", name, c, obs(), e);
      end
    end
  endtask

  task automatic test_zero_len();
    for (int c = 0; c < 5; c++) begin
      tick();
      start_i   = 1'b1;
      num_vec_i = 8'd0;
      @(negedge clk);
      checks++;
      if (raw_obs() !== 28'd0) begin
        failures++;
        $display("FAIL zero_len c%0d: got %h required %h", c, raw_obs(), 28'd0);
      end
    end
    tick();
    start_i = 1'b0;
  endtask

  task automatic test_stall();
    logic [27:0] e;
    logic [3:0]  cv;
    logic        wt, act, rv;
    logic [7:0]  addr;
    for (int c = 0; c <= 19; c++) begin
      tick();
      start_i   = (c == 0);
      num_vec_i = (c == 0) ? 8'd3 : 8'd5;
      stall_i   = (c == 6) || (c == 7);
      @(negedge clk);
      for (int j = 0; j < 4; j++) cv[j] = (c >= 8 + j) && (c <= 10 + j);
      wt   = (c >= 1) && (c <= 4);
      act  = (c == 5) || (c == 8) || (c == 9);
      addr = (c == 8) ? 8'd1 : (c == 9) ? 8'd2 : 8'd0;
      rv   = (c >= 15) && (c <= 17);
      e = expv((c >= 1) && (c <= 18), c == 18, wt, wt ? 2'(c - 1) : 2'd0, act, addr,
               (c == 5) || ((c >= 8) && (c <= 17)), cv, rv, rv ? 8'(c - 15) : 8'd0);
      checks++;
      if (obs() !== e) begin
        failures++;
        $display("FAIL stall c%0d: got %h required %h", c, obs(), e);
      end
    end
    stall_i = 1'b0;
  endtask

  task automatic test_reset_mid_job();
    for (int c = 0; c <= 11; c++) begin
      tick();
      start_i   = (c == 0);
      num_vec_i = 8'd3;
      rstn      = (c != 10);
      @(negedge clk);
      if (c == 10) begin
        checks++;
        if (busy_o !== 1'b1) begin
          failures++;
          $display("FAIL reset_mid busy_before c10: got %b required 1", busy_o);
        end
      end
      if (c == 11) begin
        checks++;
        if (raw_obs() !== 28'd0) begin
          failures++;
          $display("FAIL reset_mid after c11: got %h required %h", raw_obs(), 28'd0);
        end
      end
    end
    test_job(2, "restart_after_reset");
  endtask

  task automatic test_back_to_back();
    int acts1 = 0;
    int acts2 = 0;
    for (int c = 0; c <= 35; c++) begin
      tick();
      start_i   = (c <= 33);
      num_vec_i = ((c == 0) || (c == 17)) ? 8'd3 : (c < 17) ? 8'd7 : 8'd9;
      @(negedge clk);
      if (act_rd_en_o && (c <= 16)) acts1++;
      if (act_rd_en_o && (c >= 18)) acts2++;
      checks++;
      if (busy_o !== !((c == 0) || (c == 17) || (c >= 34))) begin
        failures++;
        $display("FAIL b2b busy c%0d: got %b", c, busy_o);
      end
      checks++;
      if (done_o !== ((c == 16) || (c == 33))) begin
        failures++;
        $display("FAIL b2b done c%0d: got %b", c, done_o);
      end
      if (c == 32) begin
        checks++;
        if ({res_valid_o, res_idx_o} !== {1'b1, 8'd2}) begin
          failures++;
          $display("FAIL b2b last_result c32: got %b/%0d required 1/2", res_valid_o, res_idx_o);
        end
      end
    end
    checks++;
    if (acts1 != 3 || acts2 != 3) begin
      failures++;
      $display("FAIL b2b act_count: got %0d,%0d required 3,3", acts1, acts2);
    end
  endtask

  initial begin
    test_reset();
    test_job(3, "basic_m3");
    test_zero_len();
    test_stall();
    test_reset_mid_job();
    test_job(1, "single_vec");
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
